text_overlay: RTL and testbench
===============================

TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 SHALL have parameter RECT_X, default 20, left edge of the text rectangle in 8-pixel blocks.
REQ-002 SHALL have parameter RECT_Y, default 20, top edge of the text rectangle in 8-pixel blocks.
REQ-003 SHALL have parameter LINES, default 10, number of text lines (2..16).
REQ-004 SHALL have parameter LENGTH, default 14, characters per line (2..32).
REQ-005 SHALL use one clock and a synchronous, active-low reset: i_clk  in  1  clock; i_rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port i_x  in  11  pixel column.
REQ-007 SHALL have port i_y  in  11  pixel row.
REQ-008 SHALL have port i_wr_valid  in  1  character write request.
REQ-009 SHALL have port o_wr_ready  out  1  write accepted when high with i_wr_valid.
REQ-010 SHALL have port i_wr_line  in  4  target line.
REQ-011 SHALL have port i_wr_col  in  5  target column.
REQ-012 SHALL have port i_wr_char  in  5  glyph code; 5'b11111 is blank.
REQ-013 SHALL have port i_clear  in  1  single-cycle request to blank the whole buffer.
REQ-014 SHALL have ports i_attr_we  in  1, i_attr_line  in  4, and i_attr_blink  in  1; together these write the per-line blink attribute.
REQ-015 SHALL have port i_frame  in  1  one-cycle pulse per video frame.
REQ-016 SHALL have ports o_char  out  5  glyph at (i_x, i_y); o_active  out  1  pixel inside the rectangle; o_busy  out  1  clear sweep running; o_wr_err  out  1  sticky out-of-range write flag.

Function
REQ-017 SHALL hold a LINES*LENGTH x 5-bit buffer at address line*LENGTH+col.
REQ-018 SHALL compute block_x=i_x[10:3] and block_y=i_y[10:3]; the pixel is inside when RECT_X<=block_x<RECT_X+LENGTH and RECT_Y<=block_y<RECT_Y+LINES.
REQ-019 SHALL register o_char and o_active exactly 1 cycle after i_x/i_y; outside the rectangle o_char=5'b11111 and o_active=0.
REQ-020 SHALL implement states IDLE and CLEAR: CLEAR writes 5'b11111 to one address per cycle from 0 to LINES*LENGTH-1, then enters IDLE.
REQ-021 SHALL enter CLEAR with the address reset to 0 on i_clear in either state; i_clear during CLEAR restarts the sweep.
REQ-022 SHALL drive o_wr_ready = (state==IDLE) && !i_clear, so i_clear wins over a simultaneous write.
REQ-023 SHALL drive o_busy = (state==CLEAR).
REQ-024 SHALL commit a write on i_wr_valid && o_wr_ready in that cycle; the buffer reflects it from the next cycle.
REQ-025 SHALL accept and discard a write with i_wr_line>=LINES or i_wr_col>=LENGTH, and set o_wr_err; o_wr_err clears only on entry to CLEAR.
REQ-026 SHALL be read-first: a read of an address written in the same cycle returns the old value.
REQ-027 SHALL hold o_char at 5'b11111 for pixels inside the rectangle while in CLEAR.

Reset
REQ-028 SHALL, with i_rst_n=0 at a clock edge, set o_char=5'b11111, o_active=0, o_wr_err=0, blink counter=0, and all blink attributes=0.
REQ-029 SHALL enter CLEAR at address 0 after reset, so o_busy=1 and o_wr_ready=0 for LINES*LENGTH cycles after release.
REQ-030 SHALL abort any operation on reset mid-operation; partial writes are not retained beyond the new sweep.

Configuration
REQ-031 SHALL, with TEXT_OVERLAY_BLINK_EN defined, keep a 5-bit counter incremented on each i_frame pulse (wrapping 31->0), store one blink bit per line via i_attr_we, and force o_char=5'b11111 on lines with blink=1 while counter[4]=1.
REQ-032 SHALL, without TEXT_OVERLAY_BLINK_EN, contain no counter or attribute storage, ignore i_attr_* and i_frame, and never blank characters for blink.

Verification
REQ-033 SHALL verify reset: hold i_rst_n=0 for 2 cycles, then release -> o_busy=1 for exactly 140 cycles (defaults), o_wr_ready=1 on cycle 141, and every in-rect o_char=5'b11111.
REQ-034 SHALL verify write/read: write line 4 col 6 char 5'b00111, then drive i_x=208, i_y=192 -> o_char=5'b00111 and o_active=1 one cycle later.
REQ-035 SHALL verify simultaneous events: i_clear and i_wr_valid in the same IDLE cycle -> write dropped, o_busy=1 next cycle, and the cell reads 5'b11111 after the sweep.
REQ-036 SHALL verify out-of-range writes: write line 10 col 0 -> o_wr_err=1 with no buffer change; i_clear -> o_wr_err=0.
REQ-037 SHALL verify blink (BLINK_EN): set blink on line 0 with char 'R' at col 0, then send 16 i_frame pulses -> o_char=5'b11111; after 16 more pulses -> o_char=5'b10001.
REQ-038 SHALL verify the rectangle boundary: i_x=159/160/271/272 at a valid row -> o_active=0/1/1/0.

Source files
------------

// File: rtl/text_overlay.sv
// Text overlay: character buffer, video-rectangle lookup and clear-sweep FSM.
// Optional per-line blink is built when TEXT_OVERLAY_BLINK_EN is defined.
module text_overlay #(
  parameter int RECT_X = 20,
  parameter int RECT_Y = 20,
  parameter int LINES  = 10,
  parameter int LENGTH = 14
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [3:0]  i_wr_line,
  input  logic [4:0]  i_wr_col,
  input  logic [4:0]  i_wr_char,
  input  logic        i_clear,
  input  logic        i_attr_we,
  input  logic [3:0]  i_attr_line,
  input  logic        i_attr_blink,
  input  logic        i_frame,
  output logic [4:0]  o_char,
  output logic        o_active,
  output logic        o_busy,
  output logic        o_wr_err
);

  localparam int DEPTH = LINES * LENGTH;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [4:0] BLANK = 5'h1F;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_addr;
  logic [4:0]      r_buf [DEPTH];
  logic [4:0]      r_char;
  logic            r_active;
  logic            r_err;

  logic            w_sweep_we;
  logic            w_wr_fire;
  logic            w_wr_ok;
  logic [9:0]      w_wr_addr;
  logic [7:0]      w_bx;
  logic [7:0]      w_by;
  logic [7:0]      w_rx;
  logic [7:0]      w_ry;
  logic [9:0]      w_rd_addr;
  logic            w_inside;
  logic            w_blink;
  logic            w_unused;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_CLEAR;
    else          r_state <= w_next;
  end

  // Next state: i_clear (re)starts the sweep, the last address ends it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_clear) w_next = S_CLEAR;
      S_CLEAR: if (i_clear) w_next = S_CLEAR;
               else if (r_addr == LAST) w_next = S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  // Handshake outputs; a clear request takes priority over a write.
  always_comb begin
    o_wr_ready = (r_state == S_IDLE) && !i_clear;
    o_busy     = (r_state == S_CLEAR);
  end

  // Sweep address, rewound on reset or on any clear request.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear)  r_addr <= '0;
    else if (o_busy)          r_addr <= (r_addr == LAST) ? '0 : r_addr + 1'b1;
  end

  assign w_sweep_we = o_busy && !i_clear;
  assign w_wr_fire  = i_wr_valid && o_wr_ready;
  assign w_wr_ok    = ({1'b0, i_wr_line} < 5'(LINES)) && ({1'b0, i_wr_col} < 6'(LENGTH));
  assign w_wr_addr  = 10'(i_wr_line) * 10'(LENGTH) + 10'(i_wr_col);

  // Buffer writes: sweep blanking or an accepted in-range host write.
  always_ff @(posedge i_clk) begin
    if (w_sweep_we)                 r_buf[r_addr] <= BLANK;
    else if (w_wr_fire && w_wr_ok)  r_buf[w_wr_addr[AW-1:0]] <= i_wr_char;
  end

  // Sticky out-of-range flag, cleared whenever a sweep starts.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear)         r_err <= 1'b0;
    else if (w_wr_fire && !w_wr_ok)  r_err <= 1'b1;
  end

  assign w_bx      = i_x[10:3];
  assign w_by      = i_y[10:3];
  assign w_rx      = w_bx - 8'(RECT_X);
  assign w_ry      = w_by - 8'(RECT_Y);
  assign w_inside  = ({1'b0, w_bx} >= 9'(RECT_X)) && ({1'b0, w_bx} < 9'(RECT_X + LENGTH)) &&
                     ({1'b0, w_by} >= 9'(RECT_Y)) && ({1'b0, w_by} < 9'(RECT_Y + LINES));
  assign w_rd_addr = 10'(w_ry) * 10'(LENGTH) + 10'(w_rx);

`ifdef TEXT_OVERLAY_BLINK_EN
  logic [4:0]  r_cnt;
  logic [15:0] r_attr;

  // Frame counter; bit 4 gives a 16-frames-on / 16-frames-off blink phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (i_frame) r_cnt <= r_cnt + 5'd1;
  end

  // Per-line blink attribute store.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_attr <= '0;
    else if (i_attr_we && ({1'b0, i_attr_line} < 5'(LINES)))
      r_attr[i_attr_line] <= i_attr_blink;
  end

  assign w_blink  = r_attr[w_ry[3:0]] && r_cnt[4];
  assign w_unused = ^{i_x[2:0], i_y[2:0], w_wr_addr[9:AW], w_rd_addr[9:AW]};
`else
  assign w_blink  = 1'b0;
  assign w_unused = ^{i_x[2:0], i_y[2:0], w_wr_addr[9:AW], w_rd_addr[9:AW],
                      i_attr_we, i_attr_line, i_attr_blink, i_frame};
`endif

  // Registered pixel lookup (read-first); blank while sweeping or blinked off.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_char   <= BLANK;
      r_active <= 1'b0;
    end else begin
      r_active <= w_inside;
      r_char   <= (w_inside && (r_state == S_IDLE) && !w_blink) ?
                  r_buf[w_rd_addr[AW-1:0]] : BLANK;
    end
  end

  assign o_char   = r_char;
  assign o_active = r_active;
  assign o_wr_err = r_err;

endmodule

// File: tb/tb_text_overlay.sv
// Bench for text_overlay: reference model plus directed scenarios.
module tb_text_overlay;
  localparam int RX = 20, RY = 20, NL = 10, NC = 14;
  localparam int N = NL * NC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_line = '0;
  logic [4:0]  wr_col = '0, wr_char = '0;
  logic        clear = 1'b0;
  logic        attr_we = 1'b0;
  logic [3:0]  attr_line = '0;
  logic        attr_blink = 1'b0;
  logic        frame = 1'b0;
  logic [4:0]  o_char;
  logic        o_active, o_busy, o_wr_err;

  int checks = 0;
  int errors = 0;

  text_overlay #(.RECT_X(RX), .RECT_Y(RY), .LINES(NL), .LENGTH(NC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_line(wr_line),
    .i_wr_col(wr_col), .i_wr_char(wr_char), .i_clear(clear),
    .i_attr_we(attr_we), .i_attr_line(attr_line), .i_attr_blink(attr_blink),
    .i_frame(frame), .o_char(o_char), .o_active(o_active), .o_busy(o_busy),
    .o_wr_err(o_wr_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: screen contents as a plain array, sweep as a cycle count.
  logic [4:0] m_buf [N];
  int         m_busy_left = N;
  bit         m_err = 0;
  logic [4:0] m_char = 5'h1F;
  bit         m_active = 0;
  bit         m_valid = 0;
  int         m_cnt = 0;
  bit         m_attr [16];

  always @(posedge clk) begin
    int bx, by, cx, cy;
    bit in_r, blank;
    if (!rst_n) begin
      m_valid = 1;
      m_busy_left = N;
      m_err = 0;
      m_char = 5'h1F;
      m_active = 0;
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_attr[i] = 0;
      for (int i = 0; i < N; i++) m_buf[i] = 5'h1F;
    end else begin
      bx = int'(x) / 8;
      by = int'(y) / 8;
      cx = bx - RX;
      cy = by - RY;
      in_r = (cx >= 0) && (cx < NC) && (cy >= 0) && (cy < NL);
      blank = 0;
`ifdef TEXT_OVERLAY_BLINK_EN
      if (in_r) blank = m_attr[cy] && (m_cnt >= 16);
`endif
      m_active = in_r;
      m_char = (in_r && m_busy_left == 0 && !blank) ? m_buf[cy * NC + cx] : 5'h1F;
`ifdef TEXT_OVERLAY_BLINK_EN
      if (frame) m_cnt = (m_cnt + 1) % 32;
      if (attr_we && int'(attr_line) < NL) m_attr[attr_line] = attr_blink;
`endif
      if (clear) begin
        m_busy_left = N;
        m_err = 0;
        for (int i = 0; i < N; i++) m_buf[i] = 5'h1F;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (wr_valid) begin
        if (int'(wr_line) < NL && int'(wr_col) < NC) m_buf[int'(wr_line) * NC + int'(wr_col)] = wr_char;
        else m_err = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_char", int'(o_char), int'(m_char));
      chk("m_active", int'(o_active), int'(m_active));
      chk("m_busy", int'(o_busy), int'(m_busy_left > 0));
      chk("m_ready", int'(wr_ready), int'((m_busy_left == 0) && !clear));
      chk("m_wr_err", int'(o_wr_err), int'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int l, input int c, input int ch);
    wr_valid = 1'b1;
    wr_line = 4'(l);
    wr_col = 5'(c);
    wr_char = 5'(ch);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pix(input int l, input int c);
    x = 11'((RX + c) * 8);
    y = 11'((RY + l) * 8);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!o_busy) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout actual=busy required=idle");
  endtask

  initial begin
    int n;
    // Reset held for two edges.
    step();
    step();
    chk("rst_char", int'(o_char), 31);
    chk("rst_active", int'(o_active), 0);
    chk("rst_err", int'(o_wr_err), 0);
    chk("rst_busy", int'(o_busy), 1);
    chk("rst_ready", int'(wr_ready), 0);
    pix(0, 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!o_busy) break;
      chk("sweep_char", int'(o_char), 31);
      n++;
      step();
    end
    chk("sweep_len", n, 140);
    chk("ready_after_sweep", int'(wr_ready), 1);

    // Write then read back; read-first on same-cycle write.
    wr(4, 6, 7);
    x = 11'd208;
    y = 11'd192;
    step();
    chk("rd_char", int'(o_char), 7);
    chk("rd_active", int'(o_active), 1);
    wr(4, 6, 9);
    chk("read_first_old", int'(o_char), 7);
    step();
    chk("read_first_new", int'(o_char), 9);

    // Clear and write in the same cycle: clear wins.
    wr(1, 1, 3);
    pix(1, 1);
    step();
    chk("pre_clear_char", int'(o_char), 3);
    clear = 1'b1;
    wr_valid = 1'b1;
    wr_line = 4'd1;
    wr_col = 5'd1;
    wr_char = 5'd5;
    #1;
    chk("clr_ready", int'(wr_ready), 0);
    step();
    clear = 1'b0;
    wr_valid = 1'b0;
    chk("clr_busy", int'(o_busy), 1);
    wait_idle();
    step();
    chk("clr_cell", int'(o_char), 31);
    x = 11'd208;
    y = 11'd192;
    step();
    chk("clr_cell2", int'(o_char), 31);

    // Out-of-range writes set the sticky flag and leave the buffer alone.
    wr(1, 0, 4);
    wr(10, 0, 2);
    chk("oor_err", int'(o_wr_err), 1);
    wr(0, 14, 6);
    chk("oor_err2", int'(o_wr_err), 1);
    pix(1, 0);
    step();
    chk("oor_no_alias", int'(o_char), 4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("oor_err_clr", int'(o_wr_err), 0);
    wait_idle();

    // Rectangle boundary.
    y = 11'd160;
    x = 11'd159; step(); chk("edge_159", int'(o_active), 0);
    x = 11'd160; step(); chk("edge_160", int'(o_active), 1);
    x = 11'd271; step(); chk("edge_271", int'(o_active), 1);
    x = 11'd272; step(); chk("edge_272", int'(o_active), 0);
    x = 11'd160;
    y = 11'd239; step(); chk("edge_y239", int'(o_active), 1);
    y = 11'd240; step(); chk("edge_y240", int'(o_active), 0);

    // Blink on line 0.
    wr(0, 0, 5'b10001);
    attr_we = 1'b1;
    attr_line = 4'd0;
    attr_blink = 1'b1;
    step();
    attr_we = 1'b0;
    pix(0, 0);
    step();
    chk("blink_pre", int'(o_char), 17);
    for (int i = 0; i < 16; i++) begin
      frame = 1'b1; step(); frame = 1'b0; step();
    end
`ifdef TEXT_OVERLAY_BLINK_EN
    chk("blink_off", int'(o_char), 31);
`else
    chk("blink_off", int'(o_char), 17);
`endif
    for (int i = 0; i < 16; i++) begin
      frame = 1'b1; step(); frame = 1'b0; step();
    end
    chk("blink_on", int'(o_char), 17);

    // Reset mid-operation discards sticky flag and contents.
    wr(15, 31, 1);
    chk("pre_rst_err", int'(o_wr_err), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", int'(o_busy), 1);
    chk("mid_rst_err", int'(o_wr_err), 0);
    chk("mid_rst_char", int'(o_char), 31);
    rst_n = 1'b1;
    wait_idle();
    step();
    chk("mid_rst_cell", int'(o_char), 31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
